multicycle_control: RTL

Multi-cycle control unit for the reduced RISC-V core and the successor to the single-cycle opcode decoder. It runs a FETCH/DECODE/EXEC/MEM/WB state machine and holds the instruction register. It decodes opcode, funct3 and funct7 for OP, OP-IMM, LOAD, STORE and BRANCH (BEQ/BNE), and sequences the datapath strobes. It handshakes with a wait-stated memory and counts retired instructions.

---
 rtl/multicycle_control.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with the
// instruction register and a retired-instruction counter.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (illegal instruction -> TRAP).
module multicycle_control #(
  parameter int unsigned ALU_CTRL_W = 3,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           instr,
  input  logic                  mem_ready,
  input  logic                  EQ,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  IRWrite,
  output logic                  PCWrite,
  output logic                  PCsrc,
  output logic                  RegWrite,
  output logic                  ALUsrc,
  output logic [ALU_CTRL_W-1:0] ALUctrl,
  output logic [1:0]            ImmSrc,
  output logic                  ResultSrc,
  output logic [31:0]           ir,
  output logic [CNT_W-1:0]      retired,
  output logic                  illegal
);

  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] IR_RESET   = 32'h0000_0013;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_op, is_op_imm, is_load, is_store, is_branch;
  logic       arith_f3_ok, legal, br_taken;
  logic [2:0] alu_op;
  logic [1:0] imm_sel;

  // Instruction field decode from the held instruction register
  always_comb begin
    opcode      = ir_q[6:0];
    funct3      = ir_q[14:12];
    funct7      = ir_q[31:25];
    is_op       = (opcode == OPC_OP);
    is_op_imm   = (opcode == OPC_OP_IMM);
    is_load     = (opcode == OPC_LOAD);
    is_store    = (opcode == OPC_STORE);
    is_branch   = (opcode == OPC_BRANCH);
    arith_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) || (funct3 == 3'b100) ||
                  (funct3 == 3'b110) || (funct3 == 3'b111);
    legal = (is_op_imm && arith_f3_ok) ||
            (is_op && arith_f3_ok &&
             ((funct7 == 7'h00) || ((funct7 == 7'h20) && (funct3 == 3'b000)))) ||
            ((is_load || is_store) && (funct3 == 3'b010)) ||
            (is_branch && (funct3[2:1] == 2'b00));
    br_taken = is_branch && (((funct3 == 3'b000) && EQ) || ((funct3 == 3'b001) && !EQ));

    alu_op = ALU_ADD;
    if (is_branch) begin
      alu_op = ALU_SUB;
    end else if (is_op || is_op_imm) begin
      case (funct3)
        3'b000:  alu_op = (is_op && funct7[5]) ? ALU_SUB : ALU_ADD;
        3'b010:  alu_op = ALU_SLT;
        3'b100:  alu_op = ALU_XOR;
        3'b110:  alu_op = ALU_OR;
        3'b111:  alu_op = ALU_AND;
        default: alu_op = ALU_ADD;
      endcase
    end

    imm_sel = 2'b00;
    if (is_store) imm_sel = 2'b01;
    else if (is_branch) imm_sel = 2'b10;
  end

  // Next-state, register updates and strobes; strobes forced low while in reset
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCsrc     = 1'b0;
    RegWrite  = 1'b0;
    ALUsrc    = 1'b0;
    ALUctrl   = '0;
    ImmSrc    = 2'b00;
    ResultSrc = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          ir_d    = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        ImmSrc = imm_sel;
        if (legal) begin
          state_d = ST_EXEC;
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d = ST_TRAP;
`else
          state_d = ST_FETCH;
`endif
        end
      end
      ST_EXEC: begin
        ImmSrc  = imm_sel;
        ALUsrc  = is_op_imm || is_load || is_store;
        ALUctrl = ALU_CTRL_W'(alu_op);
        if (is_branch) begin
          PCWrite   = br_taken;
          PCsrc     = br_taken;
          state_d   = ST_FETCH;
          retired_d = retired_q + CNT_W'(1);
        end else if (is_load || is_store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_store;
        ImmSrc  = imm_sel;
        if (mem_ready) begin
          if (is_store) begin
            state_d   = ST_FETCH;
            retired_d = retired_q + CNT_W'(1);
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        RegWrite  = 1'b1;
        ResultSrc = is_load;
        ImmSrc    = imm_sel;
        state_d   = ST_FETCH;
        retired_d = retired_q + CNT_W'(1);
      end
      ST_TRAP: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal = 1'b1;
`else
        state_d = ST_FETCH;
`endif
      end
      default: state_d = ST_FETCH;
    endcase

    if (!rst_n) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      IRWrite   = 1'b0;
      PCWrite   = 1'b0;
      PCsrc     = 1'b0;
      RegWrite  = 1'b0;
      ALUsrc    = 1'b0;
      ALUctrl   = '0;
      ImmSrc    = 2'b00;
      ResultSrc = 1'b0;
      illegal   = 1'b0;
    end
  end

  // State, instruction register and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      ir_q      <= IR_RESET;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  assign ir      = ir_q;
  assign retired = retired_q;

endmodule
